// File: rtl/data_mem_pkg.sv
`default_nettype none
// ============================================================================
// data_mem_pkg : shared encodings, FSM states and byte-lane helpers
// Revision     : 1.0
// ============================================================================
package data_mem_pkg;

  localparam int LANES  = 4;
  localparam int LANE_W = 8;
  localparam int WORD_W = 32;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_ILL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT2 = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return 3'd1;
      SIZE_HALF: return 3'd2;
      SIZE_WORD: return 3'd4;
      default:   return 3'd0;
    endcase
  endfunction

  function automatic logic [WORD_W-1:0] rotl_bytes(input logic [WORD_W-1:0] w,
                                                   input logic [1:0] n);
    logic [2*WORD_W-1:0] t;
    t = {w, w} << {n, 3'b000};
    return t[2*WORD_W-1:WORD_W];
  endfunction

  function automatic logic [WORD_W-1:0] rotr_bytes(input logic [WORD_W-1:0] w,
                                                   input logic [1:0] n);
    logic [2*WORD_W-1:0] t;
    t = {w, w} >> {n, 3'b000};
    return t[WORD_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/banked_data_mem_if.sv
`default_nettype none
// ============================================================================
// banked_data_mem_if : request/response bus of the banked data memory
// Revision           : 1.0
// ============================================================================
interface banked_data_mem_if #(
  parameter int ADDR_W = 12
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface
`default_nettype wire

// File: rtl/mem_bank.sv
`default_nettype none
// ============================================================================
// mem_bank : byte-wide synchronous-read RAM, one per byte lane (not reset)
// Revision : 1.0
// ============================================================================
module mem_bank
  import data_mem_pkg::*;
#(
  parameter int LINE_W = 10
) (
  input  logic              clock,
  input  logic              we,
  input  logic [LINE_W-1:0] addr,
  input  logic [LANE_W-1:0] din,
  output logic [LANE_W-1:0] dout
);
  logic [LANE_W-1:0] mem_q [0:(1<<LINE_W)-1];

  always_ff @(posedge clock) begin
    if (we) mem_q[addr] <= din;
    dout <= mem_q[addr];
  end
endmodule
`default_nettype wire

// File: rtl/banked_data_mem.sv
`default_nettype none
// ============================================================================
// banked_data_mem : 32-bit little-endian data memory over four byte banks;
//                   line-crossing accesses are split into two beats.
// Revision        : 1.0
// ============================================================================
module banked_data_mem
  import data_mem_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter bit MISALIGN_EN = 1'b1
) (
  input  logic             clock,
  input  logic             reset_n,
  banked_data_mem_if.slave bus
);
  localparam int LINE_W = ADDR_W - 2;

  state_e              state_q, state_d;
  logic [LINE_W-1:0]   line_q;
  logic [1:0]          off_q, size_q;
  logic                unsigned_q, write_q, err_q, cross_q;
  logic [WORD_W-1:0]   wrot_q, beat1_q;

  logic                accept, in_cross, in_err, resp;
  logic [1:0]          in_off;
  logic [3:0]          in_lim, lim_q;
  logic [LINE_W-1:0]   in_line, bank_line;
  logic [LANES-1:0]    bank_we;
  logic [WORD_W-1:0]   bank_din, bank_dout, lane_data, raw, ext;

  assign accept   = bus.req_valid && (state_q == ST_IDLE);
  assign resp     = (state_q == ST_RESP);
  assign in_off   = bus.req_addr[1:0];
  assign in_line  = bus.req_addr[ADDR_W-1:2];
  assign in_lim   = {2'b00, in_off} + {1'b0, size_bytes(bus.req_size)};
  assign lim_q    = {2'b00, off_q} + {1'b0, size_bytes(size_q)};
  assign in_cross = (in_lim > 4'd4);
  assign in_err   = (bus.req_size == SIZE_ILL) || (in_cross && !MISALIGN_EN);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = (in_cross && !in_err) ? ST_BEAT2 : ST_RESP;
      ST_BEAT2: state_d = ST_RESP;
      ST_RESP:  if (bus.rsp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      line_q     <= '0;
      off_q      <= '0;
      size_q     <= '0;
      unsigned_q <= 1'b0;
      write_q    <= 1'b0;
      err_q      <= 1'b0;
      cross_q    <= 1'b0;
      wrot_q     <= '0;
      beat1_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        line_q     <= in_line;
        off_q      <= in_off;
        size_q     <= bus.req_size;
        unsigned_q <= bus.req_unsigned;
        write_q    <= bus.req_write;
        err_q      <= in_err;
        cross_q    <= in_cross && !in_err;
        wrot_q     <= rotl_bytes(bus.req_wdata, in_off);
      end
      if (state_q == ST_BEAT2) beat1_q <= bank_dout;
    end
  end

  // In RESP the banks keep re-reading the last line so the load result stays stable.
  always_comb begin
    bank_line = cross_q ? line_q + 1'b1 : line_q;
    bank_din  = wrot_q;
    bank_we   = '0;
    case (state_q)
      ST_IDLE: begin
        bank_line = in_line;
        bank_din  = rotl_bytes(bus.req_wdata, in_off);
        for (int k = 0; k < LANES; k++)
          bank_we[k] = accept && bus.req_write && !in_err &&
                       (4'(k) >= {2'b00, in_off}) && (4'(k) < in_lim);
      end
      ST_BEAT2: begin
        bank_line = line_q + 1'b1;
        for (int k = 0; k < LANES; k++)
          bank_we[k] = write_q && (4'(k + LANES) < lim_q);
      end
      default: ;
    endcase
  end

  for (genvar g = 0; g < LANES; g++) begin : g_bank
    mem_bank #(.LINE_W(LINE_W)) u_bank (
      .clock (clock),
      .we    (bank_we[g]),
      .addr  (bank_line),
      .din   (bank_din[g*LANE_W +: LANE_W]),
      .dout  (bank_dout[g*LANE_W +: LANE_W])
    );
  end

  always_comb begin
    for (int k = 0; k < LANES; k++)
      lane_data[k*LANE_W +: LANE_W] = (cross_q && (2'(k) >= off_q)) ?
                                      beat1_q[k*LANE_W +: LANE_W] :
                                      bank_dout[k*LANE_W +: LANE_W];
    raw = rotr_bytes(lane_data, off_q);
    case (size_q)
      SIZE_BYTE: ext = {{24{raw[7]  & ~unsigned_q}}, raw[7:0]};
      SIZE_HALF: ext = {{16{raw[15] & ~unsigned_q}}, raw[15:0]};
      default:   ext = raw;
    endcase
  end

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.rsp_valid = resp;
  assign bus.rsp_err   = resp && err_q;
  assign bus.rsp_rdata = (resp && !err_q && !write_q) ? ext : '0;

endmodule
`default_nettype wire

// File: doc/banked_data_mem.md
BANKED_DATA_MEM -- requirements
Module: banked_data_mem

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, byte-address width; memory holds 2^(ADDR_W-2) 32-bit lines.
REQ-002 SHALL have parameter MISALIGN_EN, default 1, 1 = split line-crossing accesses, 0 = reject them with error.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clock  input  1  rising-edge clock.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  request accepted when high with req_valid.
REQ-008 req_write  input  1  1 = store, 0 = load.
REQ-009 req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-010 req_unsigned  input  1  zero-extend load (lbu/lhu).
REQ-011 req_addr  input  ADDR_W  byte address.
REQ-012 req_wdata  input  32  store data, LSB-aligned.
REQ-013 rsp_valid  output  1  response present, held until rsp_ready.
REQ-014 rsp_ready  input  1  response consumed.
REQ-015 rsp_rdata  output  32  load result, sign/zero-extended; 0 for stores and errors.
REQ-016 rsp_err  output  1  misaligned-rejected or illegal size; no bank written.

Function
REQ-017 SHALL store data little-endian in four byte-wide banks sharing line address addr[ADDR_W-1:2], byte lane addr[1:0].
REQ-018 SHALL implement FSM states IDLE, BEAT2, RESP; req_ready = (state == IDLE).
REQ-019 IDLE, accept, access within one line: lanes written or read at that edge; next state RESP; rsp_valid high next cycle (latency 1).
REQ-020 IDLE, accept, access crossing a line with MISALIGN_EN=1: beat 1 uses line L, lanes addr[1:0]..3; next state BEAT2 uses line L+1, lanes 0..remaining; then RESP (latency 2).
REQ-021 Line L+1 SHALL wrap modulo 2^(ADDR_W-2); top-line crossing accesses line 0.
REQ-022 Crossing access with MISALIGN_EN=0, or req_size=11, SHALL go to RESP with rsp_err=1, no write, rsp_rdata=0.
REQ-023 Store byte enables: byte = 1 lane, half = 2 lanes, word = 4 lanes; write data rotated so req_wdata[7:0] lands at lane addr[1:0].
REQ-024 Load data SHALL be reassembled from beat-1 capture and beat-2 read, then sign-extended from bit 7/15 unless req_unsigned.
REQ-025 RESP: stays RESP with rsp_valid, rsp_rdata, rsp_err stable while rsp_ready=0; rsp_valid&rsp_ready -> IDLE; no new request accepted in that same cycle.
REQ-026 Request fields SHALL be registered at accept; changes on inputs after accept have no effect.
REQ-027 Banks SHALL be synchronous-read, write-first not required; read-during-write to the same lane within one request does not occur by construction.

Reset
REQ-028 reset_n low SHALL force state IDLE, rsp_valid 0, rsp_rdata 0, rsp_err 0; req_ready 1 once state is IDLE.
REQ-029 Bank contents SHALL NOT be reset.
REQ-030 Reset during BEAT2 of a store SHALL abandon beat 2; beat-1 lanes remain written, no response issued.

Structure
REQ-031 Package data_mem_pkg SHALL hold size encodings, FSM state enum, and lane-count/width constants.
REQ-032 Sub-module mem_bank (byte-wide sync RAM, depth 2^(ADDR_W-2), we, addr, din, dout) SHALL be instantiated four times.

Verification
REQ-033 sw 0x00000010 data 0xDEADBEEF, then lw 0x010 -> rsp_rdata 0xDEADBEEF, rsp_err 0, rsp_valid 1 cycle after accept.
REQ-034 After REQ-033, lb 0x013 -> 0xFFFFFFDE; lbu 0x013 -> 0x000000DE; lh 0x012 -> 0xFFFFDEAD; lhu 0x010 -> 0x0000BEEF.
REQ-035 MISALIGN_EN=1: sw 0x016 data 0x11223344 -> lines 5/6 lanes 2,3/0,1 written, response 2 cycles after accept; lw 0x016 -> 0x11223344.
REQ-036 MISALIGN_EN=0: lh 0x003 -> rsp_err 1, rsp_rdata 0; sh 0x003 -> rsp_err 1, lines 0 and 1 unchanged.
REQ-037 ADDR_W=12, MISALIGN_EN=1: sw 0xFFE data 0xA1B2C3D4 -> line 1023 lanes 2,3 = D4,C3; line 0 lanes 0,1 = B2,A1.
REQ-038 Hold rsp_ready=0 for 5 cycles with req_valid=1 -> req_ready 0, response fields stable; reset_n low during BEAT2 -> state IDLE, rsp_valid 0 next cycle.
